// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the multiplier/divider issue controller.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MDC_IDLE,
    MDC_BUSY,
    MDC_DONE
  } multdiv_ctrl_state_e;

endpackage

// File: rtl/ibex_multdiv_issue_ctrl.sv
// Issue sequencer between ID and the multiplier/divider: holds operands for the whole
// operation, buffers one result for writeback, and aborts hung operations.
module ibex_multdiv_issue_ctrl
  import ibex_pkg::*;
#(
  parameter bit          RV32M     = 1'b1,
  parameter int unsigned MaxCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic        issue_is_div_i,
  input  md_op_e      issue_operator_i,
  input  logic [1:0]  issue_signed_mode_i,
  input  logic [31:0] issue_op_a_i,
  input  logic [31:0] issue_op_b_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output md_op_e      multdiv_operator_o,
  output logic [1:0]  multdiv_signed_mode_o,
  output logic [31:0] multdiv_op_a_o,
  output logic [31:0] multdiv_op_b_o,
  output logic        multdiv_ready_id_o,
  input  logic        multdiv_valid_i,
  input  logic [31:0] multdiv_result_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_data_o,
  output logic        perf_mul_done_o,
  output logic        perf_div_done_o,
  output logic        watchdog_err_o
);

  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  multdiv_ctrl_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic                is_div_q;
  md_op_e              operator_q;
  logic [1:0]          signed_mode_q;
  logic [31:0]         op_a_q, op_b_q, result_q;

  logic in_busy, in_done, accept, capture, timeout;

  always_comb begin
    in_busy = (state_q == MDC_BUSY);
    in_done = (state_q == MDC_DONE);
    // Gated by rst_ni so every output reads 0 while reset is held.
    issue_ready_o = rst_ni & RV32M & ~flush_i &
                    ((state_q == MDC_IDLE) | (in_done & result_ready_i));
    accept  = issue_valid_i & issue_ready_o;
    capture = in_busy & multdiv_valid_i & ~flush_i;
    // A result arriving on the limit cycle wins over the abort.
    timeout = in_busy & ~multdiv_valid_i & ~flush_i & (cnt_q == CntW'(MaxCycles - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDC_IDLE: if (accept) state_d = MDC_BUSY;
      MDC_BUSY: begin
        if (capture)      state_d = MDC_DONE;
        else if (timeout) state_d = MDC_IDLE;
      end
      MDC_DONE: begin
        if (accept)              state_d = MDC_BUSY;
        else if (result_ready_i) state_d = MDC_IDLE;
      end
      default: state_d = MDC_IDLE;
    endcase
    if (flush_i) state_d = MDC_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= MDC_IDLE;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= 2'b00;
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q      <= issue_is_div_i;
        operator_q    <= issue_operator_i;
        signed_mode_q <= issue_signed_mode_i;
        op_a_q        <= issue_op_a_i;
        op_b_q        <= issue_op_b_i;
        cnt_q         <= '0;
      end else if (in_busy) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (capture) result_q <= multdiv_result_i;
    end
  end

  assign mult_en_o             = in_busy & ~is_div_q;
  assign div_en_o              = in_busy & is_div_q;
  assign multdiv_ready_id_o    = in_busy;
  assign multdiv_operator_o    = operator_q;
  assign multdiv_signed_mode_o = signed_mode_q;
  assign multdiv_op_a_o        = op_a_q;
  assign multdiv_op_b_o        = op_b_q;
  assign result_valid_o        = in_done;
  assign result_data_o         = result_q;
  assign perf_mul_done_o       = capture & ~is_div_q;
  assign perf_div_done_o       = capture & is_div_q;
  assign watchdog_err_o        = timeout;

endmodule
